// File: rtl/systolic_seq_ctrl_if.sv
// Command / result handshake bundle between the systolic sequencer and its
// command source and result consumer.
interface systolic_seq_ctrl_if #(
   parameter int N  = 4,
   parameter int KW = 8
);
   logic                 req_val;
   logic                 req_rdy;
   logic [KW-1:0]        req_k_len;
   logic                 resp_rdy;
   logic                 resp_val;
   logic [$clog2(N)-1:0] resp_row;

   modport master (
      output req_val, req_k_len, resp_rdy,
      input  req_rdy, resp_val, resp_row
   );

   modport slave (
      input  req_val, req_k_len, resp_rdy,
      output req_rdy, resp_val, resp_row
   );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: skewed operand feed,
// accumulator freeze, then an unstallable N-row drain to the consumer.
module systolic_seq_ctrl #(
   parameter int N  = 4,
   parameter int KW = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   systolic_seq_ctrl_if.slave     bus,
   output logic [KW+$clog2(N):0]  feed_cnt,
   output logic [N-1:0]           row_en,
   output logic [N-1:0]           col_en,
   output logic                   finished,
   output logic                   shift_result,
   output logic                   busy
);
   localparam int FW = KW + $clog2(N) + 1;
   localparam int DW = $clog2(N);

   typedef enum logic [2:0] {
      IDLE, FEED, SETTLE, WAIT_DRAIN, DRAIN, DONE
   } state_t;

   state_t          state, state_nxt;
   logic [KW-1:0]   k_len;
   logic [FW-1:0]   feed_last;
   logic [DW-1:0]   drain_cnt;
   logic [N-1:0]    win;

   assign feed_last = FW'(k_len) + FW'(2 * N - 3);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         k_len        <= '0;
         feed_cnt     <= '0;
         drain_cnt    <= '0;
         bus.resp_val <= 1'b0;
         bus.resp_row <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && bus.req_val)
            k_len <= bus.req_k_len;
         // Counter only runs while staying in FEED, so every FEED entry starts at t=0.
         feed_cnt  <= (state == FEED && state_nxt == FEED) ? feed_cnt + 1'b1 : '0;
         drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
         bus.resp_val <= (state == DRAIN);
         if (state == DRAIN)
            bus.resp_row <= DW'(N - 1) - drain_cnt;
      end
   end

   always_comb begin
      state_nxt    = state;
      win          = '0;
      finished     = 1'b0;
      shift_result = 1'b0;
      bus.req_rdy  = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE: begin
            bus.req_rdy = 1'b1;
            busy        = 1'b0;
            if (bus.req_val)
               state_nxt = (bus.req_k_len == '0) ? SETTLE : FEED;
         end
         FEED: begin
            // Row i and column j share the same skew, so one window serves both edges.
            for (int unsigned i = 0; i < N; i++)
               win[i] = (feed_cnt >= FW'(i)) && (feed_cnt < FW'(i) + FW'(k_len));
            if (feed_cnt == feed_last)
               state_nxt = SETTLE;
         end
         SETTLE: begin
            finished  = 1'b1;
            state_nxt = WAIT_DRAIN;
         end
         WAIT_DRAIN: begin
            finished = 1'b1;
            if (bus.resp_rdy)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            finished     = 1'b1;
            shift_result = 1'b1;
            if (drain_cnt == DW'(N - 1))
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      row_en = win;
      col_en = win;
   end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench: a behavioural Pe grid driven by the sequencer controls, a golden
// matmul scoreboard for drained rows, and per-cycle checks of the control timeline.
module tb_systolic_seq_ctrl;
   localparam int N  = 4;
   localparam int KW = 8;
   localparam int FW = KW + $clog2(N) + 1;
   localparam int DW = $clog2(N);
   localparam int KM = 256;

   logic          clk = 1'b0;
   logic          reset;
   logic [FW-1:0] feed_cnt;
   logic [N-1:0]  row_en, col_en;
   logic          finished, shift_result, busy;

   systolic_seq_ctrl_if #(.N(N), .KW(KW)) bus ();

   systolic_seq_ctrl #(.N(N), .KW(KW)) dut (
      .clk(clk), .reset(reset), .bus(bus), .feed_cnt(feed_cnt),
      .row_en(row_en), .col_en(col_en), .finished(finished),
      .shift_result(shift_result), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int fails   = 0;
   logic [159:0] sb[$];

   int A [N][KM];
   int B [KM][N];
   int acc [N][N];
   int ar  [N][N];
   int br  [N][N];
   int pd  [N];

   function automatic int a_edge(int i);
      if (row_en[i]) return A[i][int'(feed_cnt) - i];
      return 0;
   endfunction

   function automatic int b_edge(int j);
      if (col_en[j]) return B[int'(feed_cnt) - j][j];
      return 0;
   endfunction

   // Behavioural output-stationary Pe grid with a bottom-row pass-down register.
   always @(posedge clk) begin
      int ain, bin;
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            pd[i] <= 0;
            for (int j = 0; j < N; j++) begin
               acc[i][j] <= 0; ar[i][j] <= 0; br[i][j] <= 0;
            end
         end
      end else if (shift_result) begin
         for (int j = 0; j < N; j++) begin
            pd[j] <= acc[N-1][j];
            for (int i = 0; i < N; i++)
               acc[i][j] <= (i == 0) ? 0 : acc[i-1][j];
         end
      end else if (!finished) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               ain = (j == 0) ? a_edge(i) : ar[i][j-1];
               bin = (i == 0) ? b_edge(j) : br[i-1][j];
               ar[i][j]  <= ain;
               br[i][j]  <= bin;
               acc[i][j] <= acc[i][j] + ain * bin;
            end
      end
   end

   task automatic check(string tag, logic [159:0] obs, logic [159:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [159:0] pack(logic [DW-1:0] rr, logic bz, logic rdy, logic fin,
                                         logic sh, logic rv, logic [N-1:0] re,
                                         logic [N-1:0] ce, logic [FW-1:0] fc);
      return 160'({rr, bz, rdy, fin, sh, rv, re, ce, fc});
   endfunction

   function automatic logic [159:0] obs_vec(logic in_feed);
      return pack(bus.resp_row, busy, bus.req_rdy, finished, shift_result, bus.resp_val,
                  row_en, col_en, in_feed ? feed_cnt : '0);
   endfunction

   function automatic logic [159:0] exp_vec(int c, int k, int f, int d0);
      logic fd, rv;
      logic [N-1:0] en;
      int rr;
      fd = (k > 0) && (c < f);
      for (int i = 0; i < N; i++)
         en[i] = fd && (c >= i) && (c < i + k);
      rv = (c >= d0 + 1) && (c <= d0 + N);
      rr = rv ? (N - 1 - (c - d0 - 1)) : 0;
      return pack(DW'(rr), c <= d0 + N, c > d0 + N, (c >= f) && (c < d0 + N),
                  (c >= d0) && (c < d0 + N), rv, en, en, fd ? FW'(c) : '0);
   endfunction

   task automatic tick();
      logic [159:0] e, o;
      @(posedge clk);
      #1;
      if (bus.resp_val) begin
         check("sb_pending", 160'(sb.size() > 0), 160'(1));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            o = '0;
            o[32*N +: DW] = bus.resp_row;
            for (int j = 0; j < N; j++) o[32*j +: 32] = pd[j];
            check("resp_row_data", o, e);
         end
      end
   endtask

   task automatic fill(int mode);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < KM; k++) begin
            A[i][k] = (mode == 0) ? int'(i == k) : int'($urandom_range(0, 7));
            B[k][i] = (mode == 0) ? int'(i == k) : int'($urandom_range(0, 7));
         end
   endtask

   task automatic push_golden(int k);
      logic [159:0] e;
      int s;
      for (int r = N - 1; r >= 0; r--) begin
         e = '0;
         e[32*N +: DW] = DW'(r);
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int kk = 0; kk < k; kk++) s += A[r][kk] * B[kk][j];
            e[32*j +: 32] = s;
         end
         sb.push_back(e);
      end
   endtask

   // Issues one command and checks every cycle up to and including the first IDLE cycle.
   task automatic run_op(string tag, int k, int hold, bit keep,
                         output int busy_cnt, output int max_feed);
      int f, d0;
      bit fd;
      f  = (k > 0) ? k + 2 * N - 2 : 0;
      d0 = f + 1 + hold + 1;
      busy_cnt = 0;
      max_feed = 0;
      bus.req_val   = 1'b1;
      bus.req_k_len = KW'(k);
      push_golden(k);
      tick();
      if (!keep) bus.req_val = 1'b0;
      for (int c = 0; c <= d0 + N + 1; c++) begin
         fd = (k > 0) && (c < f);
         check($sformatf("%s_cyc%0d", tag, c), obs_vec(fd), exp_vec(c, k, f, d0));
         if (busy) busy_cnt++;
         if (fd && int'(feed_cnt) > max_feed) max_feed = int'(feed_cnt);
         bus.resp_rdy = (c >= f + 1 + hold);
         if (c < d0 + N + 1) tick();
      end
      check({tag, "_sb_empty"}, 160'(sb.size()), 160'(0));
   endtask

   initial begin
      int bc, mf;
      reset         = 1'b1;
      bus.req_val   = 1'b0;
      bus.req_k_len = '0;
      bus.resp_rdy  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      check("reset_state", obs_vec(1'b1), pack('0, 0, 1, 0, 0, 0, '0, '0, '0));

      fill(0);
      run_op("k3_ident", 3, 0, 0, bc, mf);
      check("k3_feed_max", 160'(mf), 160'(8));

      run_op("k0", 0, 0, 0, bc, mf);
      check("k0_busy_cycles", 160'(bc), 160'(7));

      fill(0);
      run_op("k3_stall", 3, 5, 0, bc, mf);

      fill(1);
      run_op("held_first", 5, 0, 1, bc, mf);
      fill(1);
      run_op("held_second", 2, 0, 0, bc, mf);

      fill(1);
      bus.req_val   = 1'b1;
      bus.req_k_len = KW'(6);
      tick();
      bus.req_val = 1'b0;
      repeat (4) tick();
      check("pre_reset_feed", 160'(feed_cnt), 160'(4));
      reset = 1'b1;
      tick();
      check("mid_reset_state", obs_vec(1'b1), pack('0, 0, 1, 0, 0, 0, '0, '0, '0));
      reset = 1'b0;
      sb.delete();
      fill(1);
      run_op("after_reset_k2", 2, 0, 0, bc, mf);

      fill(1);
      run_op("k255", 255, 1, 0, bc, mf);
      check("k255_feed_max", 160'(mf), 160'(260));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
